// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle for data_mem_ctrl: master is the requester, slave is the memory.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic              err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy, err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy, err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with a fill sequencer after reset; one request per cycle in RUN,
// reads return registered data one cycle after acceptance, out-of-range accesses pulse err.
module data_mem_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int INIT_MODE = 1
) (
  input  logic           clk,
  input  logic           nReset,
  data_mem_ctrl_if.slave bus
);
  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              err_q, err_d;

  logic              busy, req_ready;
  logic              accept, in_range;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata, init_pattern;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!nReset) state_q <= S_INIT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && init_ptr_q == LAST_ADDR) state_d = S_RUN;
  end

  always_comb begin
    busy      = (state_q == S_INIT);
    req_ready = (state_q == S_RUN);
  end

  always_comb begin
    accept       = bus.req_valid & req_ready;
    in_range     = {1'b0, bus.req_addr} < DEPTH_EXT;
    init_pattern = (INIT_MODE == 1) ? DATA_W'(init_ptr_q) : '0;
    init_ptr_d   = busy ? init_ptr_q + ADDR_W'(1) : init_ptr_q;

    rsp_valid_d = accept & ~bus.req_we;
    rsp_rdata_d = rsp_rdata_q;
    if (accept && !bus.req_we) rsp_rdata_d = in_range ? mem[bus.req_addr[IDX_W-1:0]] : '0;
    err_d = accept & ~in_range;

    // The sequencer and the request port share the single write port; they never overlap.
    mem_we    = busy | (accept & bus.req_we & in_range);
    mem_waddr = busy ? init_ptr_q[IDX_W-1:0] : bus.req_addr[IDX_W-1:0];
    mem_wdata = busy ? init_pattern : bus.req_wdata;
  end

  always_ff @(posedge clk) begin
    if (nReset && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      init_ptr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      init_ptr_q  <= init_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Three memory configurations driven by directed requests; a negedge monitor scores
// every response/err pulse and every queued direct observation.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nReset;

  data_mem_ctrl_if #(.DATA_W(8), .ADDR_W(8)) if0 ();
  data_mem_ctrl_if #(.DATA_W(8), .ADDR_W(8)) if1 ();
  data_mem_ctrl_if #(.DATA_W(8), .ADDR_W(8)) if2 ();

  data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .INIT_MODE(1)) dut0 (.clk(clk), .nReset(nReset), .bus(if0));
  data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .INIT_MODE(0)) dut1 (.clk(clk), .nReset(nReset), .bus(if1));
  data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .INIT_MODE(1)) dut2 (.clk(clk), .nReset(nReset), .bus(if2));

  logic       rq_vld [3];
  logic       rq_we  [3];
  logic [7:0] rq_addr[3];
  logic [7:0] rq_wdat[3];
  logic       rs_vld [3];
  logic [7:0] rs_dat [3];
  logic       rdy    [3];
  logic       bsy    [3];
  logic       er     [3];

`define TB_HOOK(I, IFC) \
  assign IFC.req_valid = rq_vld[I]; \
  assign IFC.req_we    = rq_we[I]; \
  assign IFC.req_addr  = rq_addr[I]; \
  assign IFC.req_wdata = rq_wdat[I]; \
  assign rs_vld[I]     = IFC.rsp_valid; \
  assign rs_dat[I]     = IFC.rsp_rdata; \
  assign rdy[I]        = IFC.req_ready; \
  assign bsy[I]        = IFC.busy; \
  assign er[I]         = IFC.err;
  `TB_HOOK(0, if0)
  `TB_HOOK(1, if1)
  `TB_HOOK(2, if2)
`undef TB_HOOK

  typedef struct {
    int         inst;
    logic       rd;
    logic [7:0] data;
    logic       err;
  } exp_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } dc_t;

  exp_t sb[$];
  dc_t  dc_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: owns both counters; scores responses and queued direct observations.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rs_vld[i] || er[i]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp inst%0d: got vld=%0b dat=%02h err=%0b, none expected",
                   i, rs_vld[i], rs_dat[i], er[i]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.inst != i || e.rd != rs_vld[i] || e.err != er[i] || (e.rd && e.data != rs_dat[i])) begin
            errors++;
            $display("FAIL rsp inst%0d: got vld=%0b dat=%02h err=%0b, expected inst%0d vld=%0b dat=%02h err=%0b",
                     i, rs_vld[i], rs_dat[i], er[i], e.inst, e.rd, e.data, e.err);
          end
        end
      end
    end
    while (dc_q.size() > 0) begin
      dc_t d;
      d = dc_q.pop_front();
      checks++;
      if (d.act != d.exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", d.name, d.act, d.exp);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    dc_q.push_back('{name, act, exp});
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      rq_vld[i] = 1'b0; rq_we[i] = 1'b0; rq_addr[i] = 8'h00; rq_wdat[i] = 8'h00;
    end
  endtask

  task automatic issue(input int i, input logic we, input logic [7:0] a, input logic [7:0] d,
                       input logic exp_err, input logic [7:0] exp_d);
    int n;
    n = 0;
    while (!rdy[i] && n < 600) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 600) check($sformatf("ready_timeout_inst%0d", i), 0, 1);
    rq_vld[i] = 1'b1; rq_we[i] = we; rq_addr[i] = a; rq_wdat[i] = d;
    if (!we || exp_err) sb.push_back('{i, !we, exp_d, exp_err});
    @(posedge clk); #1;
    rq_vld[i] = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_rsp_valid%0d", tag, i), int'(rs_vld[i]), 0);
      check($sformatf("%s_rsp_rdata%0d", tag, i), int'(rs_dat[i]), 0);
      check($sformatf("%s_err%0d", tag, i), int'(er[i]), 0);
      check($sformatf("%s_busy%0d", tag, i), int'(bsy[i]), 1);
      check($sformatf("%s_ready%0d", tag, i), int'(rdy[i]), 0);
    end
  endtask

  // Counts busy cycles from release; optionally holds a write on inst0 late in the fill.
  task automatic count_init(input string tag, input bit hold);
    int cnt[3];
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (hold && k == 150) begin
        rq_vld[0] = 1'b1; rq_we[0] = 1'b1; rq_addr[0] = 8'h10; rq_wdat[0] = 8'hEE;
      end
      if (hold && k == 250) idle_all();
      for (int i = 0; i < 3; i++) if (bsy[i]) cnt[i]++;
    end
    check($sformatf("%s_busy_edges0", tag), cnt[0], 256);
    check($sformatf("%s_busy_edges1", tag), cnt[1], 256);
    check($sformatf("%s_busy_edges2", tag), cnt[2], 200);
    for (int i = 0; i < 3; i++) check($sformatf("%s_ready%0d", tag, i), int'(rdy[i]), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nReset = 1'b0;
    idle_all();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    nReset = 1'b1;
    count_init("init1", 1'b0);

    issue(0, 1'b0, 8'h2A, 8'h00, 1'b0, 8'h2A);
    issue(1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    issue(1, 1'b0, 8'h80, 8'h00, 1'b0, 8'h00);
    issue(1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00);

    issue(0, 1'b1, 8'h10, 8'h5C, 1'b0, 8'h00);
    issue(0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h5C);
    issue(0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h5C);
    issue(0, 1'b0, 8'h11, 8'h00, 1'b0, 8'h11);
    issue(0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'hFF);

    issue(2, 1'b1, 8'hC8, 8'hAA, 1'b1, 8'h00);
    issue(2, 1'b0, 8'hC8, 8'h00, 1'b1, 8'h00);
    issue(2, 1'b0, 8'hC7, 8'h00, 1'b0, 8'hC7);
    issue(2, 1'b0, 8'h48, 8'h00, 1'b0, 8'h48);
    issue(2, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);

    issue(0, 1'b1, 8'h05, 8'h77, 1'b0, 8'h00);
    issue(0, 1'b0, 8'h05, 8'h00, 1'b0, 8'h77);
    nReset = 1'b0;
    @(posedge clk); #1;
    check_reset_state("run_rst");
    nReset = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    nReset = 1'b0;
    @(posedge clk); #1;
    check_reset_state("mid_rst");
    nReset = 1'b1;
    count_init("init2", 1'b1);

    issue(0, 1'b0, 8'h05, 8'h00, 1'b0, 8'h05);
    issue(0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h10);
    issue(1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00);
    issue(2, 1'b0, 8'hC7, 8'h00, 1'b0, 8'hC7);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
